// File: rtl/ex_stage_if.sv
// EX stage bus: ID/EX operands and controls in, forwarding and pipeline
// control in, EX/MEM register contents and the busy indication out.
interface ex_stage_if #(
  parameter int XLEN = 32
);
  logic            id_valid;
  logic [XLEN-1:0] id_rs1_val;
  logic [XLEN-1:0] id_rs2_val;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rd;
  logic [3:0]      id_alu_op;
  logic            id_alu_src;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            id_mem_write;
  logic [1:0]      forward_a;
  logic [1:0]      forward_b;
  logic [XLEN-1:0] mem_fwd_data;
  logic [XLEN-1:0] wb_fwd_data;
  logic            mem_stall;
  logic            flush;
  logic            ex_busy;
  logic            exm_valid;
  logic            exm_reg_write;
  logic            exm_mem_read;
  logic            exm_mem_write;
  logic [XLEN-1:0] exm_alu_result;
  logic [XLEN-1:0] exm_store_data;
  logic [4:0]      exm_rd;

  // Upstream pipeline / environment side.
  modport master (
    output id_valid, id_rs1_val, id_rs2_val, id_imm, id_rd, id_alu_op,
           id_alu_src, id_reg_write, id_mem_read, id_mem_write,
           forward_a, forward_b, mem_fwd_data, wb_fwd_data, mem_stall, flush,
    input  ex_busy, exm_valid, exm_reg_write, exm_mem_read, exm_mem_write,
           exm_alu_result, exm_store_data, exm_rd
  );

  // Execute stage side.
  modport slave (
    input  id_valid, id_rs1_val, id_rs2_val, id_imm, id_rd, id_alu_op,
           id_alu_src, id_reg_write, id_mem_read, id_mem_write,
           forward_a, forward_b, mem_fwd_data, wb_fwd_data, mem_stall, flush,
    output ex_busy, exm_valid, exm_reg_write, exm_mem_read, exm_mem_write,
           exm_alu_result, exm_store_data, exm_rd
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, single-cycle ALU, 32-iteration shift-add
// multiplier, and the EX/MEM pipeline register.
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  ex_stage_if.slave   ex
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_PASSB = 4'd11;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [4:0]      cnt_r;

  logic [XLEN-1:0] fwd_a_s;
  logic [XLEN-1:0] fwd_b_s;
  logic [XLEN-1:0] op_b_s;
  logic [4:0]      shamt_s;
  logic [XLEN-1:0] alu_res_s;

  logic            accept_s;
  logic            is_mul_s;
  logic            mul_start_s;
  logic            mul_step_s;
  logic            mul_done_s;
  logic            mul_abort_s;

  logic [XLEN-1:0] a_sh_r;
  logic [XLEN-1:0] b_sh_r;
  logic [XLEN-1:0] acc_r;
  logic [XLEN-1:0] mul_store_r;
  logic [4:0]      mul_rd_r;
  logic            mul_reg_write_r;
  logic            mul_mem_read_r;
  logic            mul_mem_write_r;
  logic [XLEN-1:0] mul_partial_s;
  logic [XLEN-1:0] mul_product_s;

  logic            exm_valid_r;
  logic            exm_reg_write_r;
  logic            exm_mem_read_r;
  logic            exm_mem_write_r;
  logic [XLEN-1:0] exm_alu_result_r;
  logic [XLEN-1:0] exm_store_data_r;
  logic [4:0]      exm_rd_r;

  // Forwarding muxes and operand-B immediate select.
  always_comb begin
    fwd_a_s = ex.id_rs1_val;
    fwd_b_s = ex.id_rs2_val;
    op_b_s  = ex.id_rs2_val;
    case (ex.forward_a)
      2'b10:   fwd_a_s = ex.mem_fwd_data;
      2'b01:   fwd_a_s = ex.wb_fwd_data;
      default: fwd_a_s = ex.id_rs1_val;
    endcase
    case (ex.forward_b)
      2'b10:   fwd_b_s = ex.mem_fwd_data;
      2'b01:   fwd_b_s = ex.wb_fwd_data;
      default: fwd_b_s = ex.id_rs2_val;
    endcase
    if (ex.id_alu_src) begin
      op_b_s = ex.id_imm;
    end else begin
      op_b_s = fwd_b_s;
    end
  end

  assign shamt_s = op_b_s[4:0];

  // Single-cycle ALU; MUL is handled by the iterative unit, reserved codes give zero.
  always_comb begin
    alu_res_s = {XLEN{1'b0}};
    case (ex.id_alu_op)
      OP_ADD:   alu_res_s = fwd_a_s + op_b_s;
      OP_SUB:   alu_res_s = fwd_a_s - op_b_s;
      OP_AND:   alu_res_s = fwd_a_s & op_b_s;
      OP_OR:    alu_res_s = fwd_a_s | op_b_s;
      OP_XOR:   alu_res_s = fwd_a_s ^ op_b_s;
      OP_SLL:   alu_res_s = fwd_a_s << shamt_s;
      OP_SRL:   alu_res_s = fwd_a_s >> shamt_s;
      OP_SRA:   alu_res_s = $unsigned($signed(fwd_a_s) >>> shamt_s);
      OP_SLT:   alu_res_s = {{(XLEN-1){1'b0}}, ($signed(fwd_a_s) < $signed(op_b_s))};
      OP_SLTU:  alu_res_s = {{(XLEN-1){1'b0}}, (fwd_a_s < op_b_s)};
      OP_PASSB: alu_res_s = op_b_s;
      default:  alu_res_s = {XLEN{1'b0}};
    endcase
  end

  assign is_mul_s      = (ex.id_alu_op == OP_MUL);
  assign accept_s      = ex.id_valid & (state_r == ST_IDLE) & ~ex.mem_stall & ~ex.flush;
  assign mul_partial_s = b_sh_r[0] ? a_sh_r : {XLEN{1'b0}};
  assign mul_product_s = acc_r + mul_partial_s;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: flush wins over completion; completion waits for MEM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && is_mul_s) begin
          state_nxt_s = ST_MUL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (ex.flush) begin
          state_nxt_s = ST_IDLE;
        end else if ((cnt_r == 5'd31) && !ex.mem_stall) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_MUL;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: busy flag and multiplier control strobes.
  always_comb begin
    mul_start_s = 1'b0;
    mul_step_s  = 1'b0;
    mul_done_s  = 1'b0;
    mul_abort_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        mul_start_s = accept_s & is_mul_s;
      end
      ST_MUL: begin
        mul_abort_s = ex.flush;
        mul_done_s  = ~ex.flush & (cnt_r == 5'd31) & ~ex.mem_stall;
        // The last iteration is frozen while MEM stalls so the sum is not re-added.
        mul_step_s  = ~ex.flush & ~((cnt_r == 5'd31) & ex.mem_stall);
      end
      default: begin
        mul_start_s = 1'b0;
      end
    endcase
  end

  assign ex.ex_busy = (state_r == ST_MUL);

  // Multiplier operand latches, partial-sum accumulator and iteration counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r           <= 5'd0;
      a_sh_r          <= {XLEN{1'b0}};
      b_sh_r          <= {XLEN{1'b0}};
      acc_r           <= {XLEN{1'b0}};
      mul_store_r     <= {XLEN{1'b0}};
      mul_rd_r        <= 5'd0;
      mul_reg_write_r <= 1'b0;
      mul_mem_read_r  <= 1'b0;
      mul_mem_write_r <= 1'b0;
    end else if (mul_start_s) begin
      cnt_r           <= 5'd0;
      a_sh_r          <= fwd_a_s;
      b_sh_r          <= op_b_s;
      acc_r           <= {XLEN{1'b0}};
      mul_store_r     <= fwd_b_s;
      mul_rd_r        <= ex.id_rd;
      mul_reg_write_r <= ex.id_reg_write;
      mul_mem_read_r  <= ex.id_mem_read;
      mul_mem_write_r <= ex.id_mem_write;
    end else if (mul_abort_s) begin
      cnt_r <= 5'd0;
    end else if (mul_step_s) begin
      acc_r  <= mul_product_s;
      a_sh_r <= a_sh_r << 1;
      b_sh_r <= b_sh_r >> 1;
      cnt_r  <= cnt_r + 5'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // EX/MEM register: hold on MEM stall, else load MUL product, ALU result, or a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exm_valid_r      <= 1'b0;
      exm_reg_write_r  <= 1'b0;
      exm_mem_read_r   <= 1'b0;
      exm_mem_write_r  <= 1'b0;
      exm_alu_result_r <= {XLEN{1'b0}};
      exm_store_data_r <= {XLEN{1'b0}};
      exm_rd_r         <= 5'd0;
    end else if (ex.mem_stall) begin
      exm_valid_r      <= exm_valid_r;
    end else if (mul_done_s) begin
      exm_valid_r      <= 1'b1;
      exm_reg_write_r  <= mul_reg_write_r;
      exm_mem_read_r   <= mul_mem_read_r;
      exm_mem_write_r  <= mul_mem_write_r;
      exm_alu_result_r <= mul_product_s;
      exm_store_data_r <= mul_store_r;
      exm_rd_r         <= mul_rd_r;
    end else if (accept_s && !is_mul_s) begin
      exm_valid_r      <= 1'b1;
      exm_reg_write_r  <= ex.id_reg_write;
      exm_mem_read_r   <= ex.id_mem_read;
      exm_mem_write_r  <= ex.id_mem_write;
      exm_alu_result_r <= alu_res_s;
      exm_store_data_r <= fwd_b_s;
      exm_rd_r         <= ex.id_rd;
    end else begin
      exm_valid_r      <= 1'b0;
      exm_reg_write_r  <= 1'b0;
      exm_mem_read_r   <= 1'b0;
      exm_mem_write_r  <= 1'b0;
      exm_alu_result_r <= {XLEN{1'b0}};
      exm_store_data_r <= {XLEN{1'b0}};
      exm_rd_r         <= 5'd0;
    end
  end

  assign ex.exm_valid      = exm_valid_r;
  assign ex.exm_reg_write  = exm_reg_write_r;
  assign ex.exm_mem_read   = exm_mem_read_r;
  assign ex.exm_mem_write  = exm_mem_write_r;
  assign ex.exm_alu_result = exm_alu_result_r;
  assign ex.exm_store_data = exm_store_data_r;
  assign ex.exm_rd         = exm_rd_r;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, forwarding, multiplier latency,
// stall/flush interaction and asynchronous reset.
module tb_ex_stage;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  ex_stage_if #(.XLEN(32)) bus ();

  ex_stage #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .ex  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t vecs [10];

  // One comparison: count it and report a mismatch.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction with no forwarding and register operand B.
  task automatic set_op(input logic valid, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.id_valid     = valid;
    bus.id_alu_op    = op;
    bus.id_rs1_val   = a;
    bus.id_rs2_val   = b;
    bus.id_rd        = rd;
    bus.id_alu_src   = 1'b0;
    bus.id_imm       = 32'd0;
    bus.forward_a    = 2'b00;
    bus.forward_b    = 2'b00;
    bus.id_reg_write = 1'b1;
    bus.id_mem_read  = 1'b0;
    bus.id_mem_write = 1'b0;
  endtask

  initial begin
    int ticks;
    int busy_cycles;
    int pulses;
    n_checks = 0;
    n_errors = 0;

    vecs[0] = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
    vecs[1] = '{4'd2,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200};
    vecs[2] = '{4'd3,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F};
    vecs[3] = '{4'd4,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555};
    vecs[4] = '{4'd5,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002};
    vecs[5] = '{4'd6,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000};
    vecs[6] = '{4'd7,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
    vecs[7] = '{4'd8,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    vecs[8] = '{4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[9] = '{4'd12, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000};

    rst = 1'b1;
    set_op(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    bus.mem_fwd_data = 32'd0;
    bus.wb_fwd_data  = 32'd0;
    bus.mem_stall    = 1'b0;
    bus.flush        = 1'b0;
    tick();
    tick();
    check_eq("rst_valid",  {31'd0, bus.exm_valid}, 32'd0);
    check_eq("rst_result", bus.exm_alu_result, 32'd0);
    check_eq("rst_busy",   {31'd0, bus.ex_busy}, 32'd0);
    rst = 1'b0;

    // ADD 5 + 7
    set_op(1'b1, 4'd0, 32'd5, 32'd7, 5'd3);
    tick();
    check_eq("add_result", bus.exm_alu_result, 32'd12);
    check_eq("add_valid",  {31'd0, bus.exm_valid}, 32'd1);
    check_eq("add_rd",     {27'd0, bus.exm_rd}, 32'd3);
    check_eq("add_store",  bus.exm_store_data, 32'd7);

    // SUB with A from MEM and B from WB
    set_op(1'b1, 4'd1, 32'd1, 32'd2, 5'd4);
    bus.forward_a    = 2'b10;
    bus.mem_fwd_data = 32'd100;
    bus.forward_b    = 2'b01;
    bus.wb_fwd_data  = 32'd30;
    tick();
    check_eq("sub_fwd_result", bus.exm_alu_result, 32'd70);
    check_eq("sub_fwd_store",  bus.exm_store_data, 32'd30);

    // forward_a=11 selects rs1; immediate as B; store still takes rs2
    set_op(1'b1, 4'd0, 32'd9, 32'h55, 5'd5);
    bus.forward_a  = 2'b11;
    bus.id_alu_src = 1'b1;
    bus.id_imm     = 32'd20;
    tick();
    check_eq("fwd11_imm_result", bus.exm_alu_result, 32'd29);
    check_eq("fwd11_store",      bus.exm_store_data, 32'h55);

    // ALU op table
    for (int i = 0; i < 10; i++) begin
      set_op(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 5'd1);
      tick();
      check_eq($sformatf("alu_op%0d", vecs[i].op), bus.exm_alu_result, vecs[i].exp);
    end

    // Bubble when nothing is accepted
    set_op(1'b0, 4'd0, 32'd1, 32'd1, 5'd1);
    tick();
    check_eq("bubble_valid",  {31'd0, bus.exm_valid}, 32'd0);
    check_eq("bubble_result", bus.exm_alu_result, 32'd0);

    // MUL 0xFFFFFFFF * 3, inputs scrambled after accept
    set_op(1'b1, 4'd10, 32'hFFFF_FFFF, 32'd3, 5'd7);
    tick();
    set_op(1'b0, 4'd0, 32'h1357_9BDF, 32'h0000_0777, 5'd2);
    bus.forward_a = 2'b10;
    busy_cycles = bus.ex_busy ? 1 : 0;
    ticks = 0;
    while (!bus.exm_valid && ticks < 40) begin
      tick();
      ticks++;
      if (bus.ex_busy) busy_cycles++;
    end
    check_eq("mul_latency",    ticks + 1, 33);
    check_eq("mul_busy_cyc",   busy_cycles, 32);
    check_eq("mul_result",     bus.exm_alu_result, 32'hFFFF_FFFD);
    check_eq("mul_rd",         {27'd0, bus.exm_rd}, 32'd7);
    check_eq("mul_valid",      {31'd0, bus.exm_valid}, 32'd1);

    // MUL with MEM stall at counter 31 for 4 cycles
    set_op(1'b1, 4'd10, 32'h0001_2345, 32'h0000_0100, 5'd9);
    tick();
    set_op(1'b0, 4'd0, 32'hDEAD_BEEF, 32'h0000_00FF, 5'd2);
    bus.forward_a    = 2'b10;
    bus.mem_fwd_data = 32'h0BAD_F00D;
    repeat (31) tick();
    check_eq("stall_pre_busy",  {31'd0, bus.ex_busy}, 32'd1);
    check_eq("stall_pre_valid", {31'd0, bus.exm_valid}, 32'd0);
    bus.mem_stall = 1'b1;
    busy_cycles = 0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.ex_busy) busy_cycles++;
      if (bus.exm_valid) pulses++;
    end
    check_eq("stall_busy_held", busy_cycles, 4);
    check_eq("stall_no_valid",  pulses, 0);
    bus.mem_stall = 1'b0;
    tick();
    check_eq("stall_mul_valid",  {31'd0, bus.exm_valid}, 32'd1);
    check_eq("stall_mul_result", bus.exm_alu_result, 32'h0123_4500);
    check_eq("stall_mul_busy",   {31'd0, bus.ex_busy}, 32'd0);

    // Flush at counter 10
    set_op(1'b1, 4'd10, 32'd6, 32'd7, 5'd11);
    tick();
    bus.id_valid = 1'b0;
    repeat (10) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check_eq("flush_idle", {31'd0, bus.ex_busy}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 35; i++) begin
      tick();
      if (bus.exm_valid) pulses++;
    end
    check_eq("flush_no_pulse", pulses, 0);
    set_op(1'b1, 4'd0, 32'd3, 32'd4, 5'd12);
    tick();
    check_eq("flush_next_add", bus.exm_alu_result, 32'd7);
    check_eq("flush_next_vld", {31'd0, bus.exm_valid}, 32'd1);

    // Stall holds EX/MEM even with flush
    set_op(1'b1, 4'd0, 32'd10, 32'd20, 5'd13);
    tick();
    set_op(1'b1, 4'd1, 32'd1, 32'd1, 5'd14);
    bus.mem_stall = 1'b1;
    bus.flush     = 1'b1;
    tick();
    tick();
    check_eq("hold_result", bus.exm_alu_result, 32'd30);
    check_eq("hold_valid",  {31'd0, bus.exm_valid}, 32'd1);
    check_eq("hold_rd",     {27'd0, bus.exm_rd}, 32'd13);
    bus.mem_stall = 1'b0;
    bus.flush     = 1'b0;

    // Async reset mid-cycle clears EX/MEM immediately
    set_op(1'b1, 4'd0, 32'd6, 32'd7, 5'd15);
    tick();
    check_eq("pre_rst_result", bus.exm_alu_result, 32'd13);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_valid",  {31'd0, bus.exm_valid}, 32'd0);
    check_eq("arst_result", bus.exm_alu_result, 32'd0);
    check_eq("arst_rd",     {27'd0, bus.exm_rd}, 32'd0);
    check_eq("arst_rw",     {31'd0, bus.exm_reg_write}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Async reset mid-MUL discards it; first accept right after release
    set_op(1'b1, 4'd10, 32'd2, 32'd3, 5'd16);
    tick();
    bus.id_valid = 1'b0;
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    check_eq("arst_busy", {31'd0, bus.ex_busy}, 32'd0);
    tick();
    set_op(1'b1, 4'd0, 32'd1, 32'd1, 5'd17);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_eq("post_rst_add",  bus.exm_alu_result, 32'd2);
    check_eq("post_rst_vld",  {31'd0, bus.exm_valid}, 32'd1);
    bus.id_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.exm_valid) pulses++;
    end
    check_eq("discard_no_pulse", pulses, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
